raster_line_writer: RTL and testbench
=====================================

Name: raster_line_writer

Overview:
Output-side counterpart to the input line buffer. Accepts one 2x2 upscaled pixel block per input pixel and re-serialises the blocks into raster order. For each input row it emits output row 2y (top pairs) directly. It stores the bottom pairs in a line RAM, then replays them as output row 2y+1. Sits between the interpolation core and the video/frame sink.

Parameters:
DATA_WIDTH, 8, bits per pixel
IMG_WIDTH, 128, input pixels per row; each output row is 2*IMG_WIDTH pixels
IMG_HEIGHT, 128, input rows per frame; used only with RASTER_EOF_EN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  block available
in_ready  out  1  block accepted when in_valid && in_ready
in_p00  in  DATA_WIDTH  top-left output pixel
in_p01  in  DATA_WIDTH  top-right
in_p10  in  DATA_WIDTH  bottom-left
in_p11  in  DATA_WIDTH  bottom-right
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts when out_valid && out_ready
out_data  out  DATA_WIDTH  output pixel, raster order
out_last  out  1  high on the final beat of every output row
out_eof  out  1  present only with RASTER_EOF_EN

Behaviour:
- Reset (async, rst_n=0): state=S_FILL, col=0, hold regs=0, out_valid=0, out_data=0, out_last=0, out_eof=0. RAM contents are not cleared. A reset mid-row discards the row.
- Line RAM: IMG_WIDTH words of 2*DATA_WIDTH holding {p11,p10}. Write and read are synchronous, with 1-cycle read latency.
- col counter: width $clog2(IMG_WIDTH), wraps IMG_WIDTH-1 -> 0.
- S_FILL: in_ready=1, out_valid=0. On accept: hold<={p01,p00}, ram[col]<={p11,p10}, go to S_TEVEN.
- S_TEVEN: out_valid=1, out_data=hold p00, out_last=0. On out_ready go to S_TODD.
- S_TODD: out_data=hold p01, out_last=(col==IMG_WIDTH-1).
- S_TODD, in_ready rule: in_ready = out_ready && col!=IMG_WIDTH-1. This gives back-to-back blocks: a simultaneous output handshake and input accept loads hold and RAM, col++, and goes to S_TEVEN.
- S_TODD, output handshake without input accept: if col!=last, col++ and go to S_FILL; else col<=0 and go to S_RD.
- S_RD: issue read ram[col], out_valid=0, in_ready=0, 1 cycle, then go to S_BEVEN.
- S_BEVEN: out_data=p10 of the read word. On out_ready go to S_BODD.
- S_BODD: out_data=p11, out_last=(col==IMG_WIDTH-1). On out_ready: if col==last, col<=0 and go to S_FILL; else col++ and go to S_RD.
- in_ready=0 throughout S_TEVEN, S_RD, S_BEVEN and S_BODD. The RAM is never written while a bottom row drains.
- Backpressure: out_data and out_last stay stable while out_valid && !out_ready. Input is never lost; in_ready is low whenever a block cannot be stored.
- Throughput:
  - Top row: 1 pixel/cycle with continuous in_valid/out_ready.
  - Bottom row: 2 pixels per 3 cycles.
  - Exactly one idle output cycle (S_RD) follows every top row.

Optional Feature:
RASTER_EOF_EN
- Defined: adds port out_eof and an input row counter (0..IMG_HEIGHT-1, incremented on the last bottom-row handshake).
- out_eof=1 together with out_last on the final beat of bottom row IMG_HEIGHT-1. The counter then wraps to 0 and resets with rst_n.
- Undefined: no counter, no out_eof port. All other behaviour is identical.

Decomposition:
- Shared package upscaler_pkg holds:
  - DATA_WIDTH default
  - state encodings S_FILL, S_TEVEN, S_TODD, S_RD, S_BEVEN, S_BODD (3-bit)
  - pixel-pair width constant 2*DATA_WIDTH
- One sub-module, pair_line_ram: simple dual-port RAM, 1 write port, 1 registered read port, parameterised width/depth.

Test Plan:
- IMG_WIDTH=4, reset then blocks k=0..3 with p00=4k, p01=4k+1, p10=4k+2, p11=4k+3, out_ready=1 -> out stream 0,1,4,5,8,9,12,13 then 2,3,6,7,10,11,14,15. out_last only on beats 13 and 15.
- Same stimulus -> exactly one out_valid=0 cycle between beat 13 and beat 2. Bottom row shows out_valid=0 for one cycle before each pair.
- out_ready toggled randomly (50%) -> identical data sequence to the first test. out_data is held stable on every stalled cycle. No in_valid block dropped or duplicated.
- in_valid held high during the bottom-row drain -> in_ready=0 until S_FILL. The next block is accepted on the first S_FILL cycle.
- Assert rst_n=0 asynchronously mid-way through the top row (after beat 5) -> out_valid=0 immediately. After release, a fresh row of blocks yields the correct stream starting at col 0.
- RASTER_EOF_EN, IMG_WIDTH=4, IMG_HEIGHT=2, two full rows -> out_eof=1 only on the final beat of output row 3. No pulse in the first half-frame. The counter wraps for the next frame.

Source files
------------

// File: rtl/upscaler_pkg.sv
// upscaler_pkg: shared constants and state encoding for the
// 2x upscaler output path (raster_line_writer and its line RAM).
package upscaler_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PAIR_WIDTH = 2 * DATA_WIDTH_DEF;

  typedef enum logic [2:0] {
    S_FILL  = 3'd0,
    S_TEVEN = 3'd1,
    S_TODD  = 3'd2,
    S_RD    = 3'd3,
    S_BEVEN = 3'd4,
    S_BODD  = 3'd5
  } state_t;

  function automatic int pair_width(input int dw);
    return 2 * dw;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pair_line_ram.sv
// pair_line_ram: simple dual-port line RAM, one write port and
// one read port with a registered (1-cycle latency) output.
module pair_line_ram
  import upscaler_pkg::*;
#(
  parameter int WIDTH = PAIR_WIDTH,
  parameter int DEPTH = 128,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store a bottom pixel pair.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered output, held until the next read.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/raster_line_writer.sv
// raster_line_writer: serialises 2x2 blocks into raster order.
// Optional end-of-frame flag: define RASTER_EOF_EN.
module raster_line_writer
  import upscaler_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_p00,
  input  logic [DATA_WIDTH-1:0] in_p01,
  input  logic [DATA_WIDTH-1:0] in_p10,
  input  logic [DATA_WIDTH-1:0] in_p11,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
`ifdef RASTER_EOF_EN
  ,
  output logic                  out_eof
`endif
);

  localparam int PW = pair_width(DATA_WIDTH);
  localparam int CW = addr_width(IMG_WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);

  if (IMG_WIDTH < 2 || IMG_HEIGHT < 1) begin : g_bad_dims
    $error("raster_line_writer: bad image dimensions");
  end

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]         col;
  logic [CW-1:0]         col_nxt;
  logic                  col_end;
  logic [DATA_WIDTH-1:0] hold_p00;
  logic [DATA_WIDTH-1:0] hold_p01;
  logic                  load;
  logic                  ram_we;
  logic [CW-1:0]         ram_waddr;
  logic                  ram_re;
  logic [PW-1:0]         ram_rdata;
  logic                  row_done;

  assign col_end = (col == COL_LAST);

  pair_line_ram #(
    .WIDTH (PW),
    .DEPTH (IMG_WIDTH),
    .AW    (CW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata ({in_p11, in_p10}),
    .re    (ram_re),
    .raddr (col),
    .rdata (ram_rdata)
  );

  // State, column and top-pair hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FILL;
      col      <= '0;
      hold_p00 <= '0;
      hold_p01 <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      if (load) begin
        hold_p00 <= in_p00;
        hold_p01 <= in_p01;
      end
    end
  end

  // Next state, handshakes, RAM control and output mux.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    load      = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = col;
    ram_re    = 1'b0;
    row_done  = 1'b0;
    unique case (state)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          ram_we    = 1'b1;
          state_nxt = S_TEVEN;
        end
      end
      S_TEVEN: begin
        out_valid = 1'b1;
        out_data  = hold_p00;
        if (out_ready) state_nxt = S_TODD;
      end
      S_TODD: begin
        out_valid = 1'b1;
        out_data  = hold_p01;
        out_last  = col_end;
        in_ready  = out_ready && !col_end;
        if (out_ready) begin
          if (col_end) begin
            col_nxt   = '0;
            state_nxt = S_RD;
          end else begin
            col_nxt = col + COL_ONE;
            if (in_valid) begin
              load      = 1'b1;
              ram_we    = 1'b1;
              ram_waddr = col + COL_ONE;
              state_nxt = S_TEVEN;
            end else begin
              state_nxt = S_FILL;
            end
          end
        end
      end
      S_RD: begin
        ram_re    = 1'b1;
        state_nxt = S_BEVEN;
      end
      S_BEVEN: begin
        out_valid = 1'b1;
        out_data  = ram_rdata[DATA_WIDTH-1:0];
        if (out_ready) state_nxt = S_BODD;
      end
      S_BODD: begin
        out_valid = 1'b1;
        out_data  = ram_rdata[PW-1:DATA_WIDTH];
        out_last  = col_end;
        if (out_ready) begin
          if (col_end) begin
            col_nxt   = '0;
            row_done  = 1'b1;
            state_nxt = S_FILL;
          end else begin
            col_nxt   = col + COL_ONE;
            state_nxt = S_RD;
          end
        end
      end
      default: begin
        state_nxt = S_FILL;
      end
    endcase
  end

`ifdef RASTER_EOF_EN
  localparam int RW = addr_width(IMG_HEIGHT);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [RW-1:0] row;

  // Input row counter, advanced when a bottom row completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
    end else if (row_done) begin
      row <= (row == ROW_LAST) ? '0 : row + ROW_ONE;
    end
  end

  assign out_eof = (state == S_BODD) && col_end
                && (row == ROW_LAST);
`else
  logic unused_row_done;
  assign unused_row_done = row_done;
`endif

endmodule

// File: tb/tb_raster_line_writer.sv
// tb_raster_line_writer: directed self-checking bench for
// raster_line_writer with IMG_WIDTH=4, IMG_HEIGHT=2.
module tb_raster_line_writer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_p00 = '0;
  logic [DW-1:0] in_p01 = '0;
  logic [DW-1:0] in_p10 = '0;
  logic [DW-1:0] in_p11 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          eof_w;
`ifdef RASTER_EOF_EN
  logic          out_eof;
  assign eof_w = out_eof;
`else
  assign eof_w = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] q_data[$];
  bit            q_last[$];
  bit            q_eof[$];
  bit            cyc_ov[$];
  bit            cyc_ir[$];
  bit            cyc_ihs[$];
  int            accepted;
  int            stall_err;
  bit            timed_out;

  raster_line_writer #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p00    (in_p00),
    .in_p01    (in_p01),
    .in_p10    (in_p10),
    .in_p11    (in_p11),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef RASTER_EOF_EN
    ,
    .out_eof   (out_eof)
`endif
  );

  always #5 clk = ~clk;

  // Expected pixel for output beat i of a stream of blocks k
  // with p00=base+4k, p01=+1, p10=+2, p11=+3.
  function automatic logic [DW-1:0] exp_data(input int base,
                                             input int i);
    int row, j, half, m, k;
    row  = i / (4 * W);
    j    = i % (4 * W);
    half = j / (2 * W);
    m    = j % (2 * W);
    k    = row * W + m / 2;
    return DW'(base + 4 * k + 2 * half + m % 2);
  endfunction

  function automatic bit exp_last(input int i);
    return (i % (2 * W)) == (2 * W - 1);
  endfunction

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input int nblk, input int nbeats,
                       input bit rnd, input int base);
    int k;
    int cyc;
    bit pstall;
    logic [DW-1:0] pdata;
    bit plast;
    k = 0;
    cyc = 0;
    pstall = 1'b0;
    pdata = '0;
    plast = 1'b0;
    q_data.delete();
    q_last.delete();
    q_eof.delete();
    cyc_ov.delete();
    cyc_ir.delete();
    cyc_ihs.delete();
    stall_err = 0;
    timed_out = 1'b0;
    while (q_data.size() < nbeats && cyc < 3000) begin
      @(negedge clk);
      in_valid  = (k < nblk);
      in_p00    = DW'(base + 4 * k);
      in_p01    = DW'(base + 4 * k + 1);
      in_p10    = DW'(base + 4 * k + 2);
      in_p11    = DW'(base + 4 * k + 3);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (pstall && (!out_valid || out_data !== pdata
                     || out_last !== plast))
        stall_err++;
      cyc_ov.push_back(out_valid);
      cyc_ir.push_back(in_ready);
      cyc_ihs.push_back(in_valid && in_ready);
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_last.push_back(out_last);
        q_eof.push_back(eof_w);
      end
      if (in_valid && in_ready) k++;
      pstall = out_valid && !out_ready;
      pdata  = out_data;
      plast  = out_last;
      cyc++;
    end
    accepted = k;
    if (q_data.size() < nbeats) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ov got=%b exp=0", out_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ir got=%b exp=1", in_ready);
    end
    checks++;
    if (out_data !== '0 || out_last !== 1'b0
        || eof_w !== 1'b0) begin
      failures++;
      $display("FAIL reset_outs data=%0d last=%b eof=%b exp=0",
               out_data, out_last, eof_w);
    end
  endtask

  task automatic test_stream();
    do_reset();
    drive(W, 4 * W, 1'b0, 0);
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL stream_timeout beats=%0d exp=%0d",
               q_data.size(), 4 * W);
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_data(0, i)
          || q_last[i] !== exp_last(i)) begin
        failures++;
        $display("FAIL stream_beat%0d got=%0d/%b exp=%0d/%b",
                 i, q_data[i], q_last[i],
                 exp_data(0, i), exp_last(i));
      end
    end
    for (int c = 0; c < cyc_ov.size() && c < 21; c++) begin
      bit e;
      if (c == 0) e = 1'b0;
      else if (c <= 8) e = 1'b1;
      else e = ((c - 9) % 3) != 0;
      checks++;
      if (cyc_ov[c] !== e) begin
        failures++;
        $display("FAIL gap_cycle%0d out_valid got=%b exp=%b",
                 c, cyc_ov[c], e);
      end
    end
  endtask

  task automatic test_drain();
    int bad;
    do_reset();
    drive(2 * W, 8 * W, 1'b0, 0);
    checks++;
    if (timed_out || cyc_ir.size() < 22) begin
      failures++;
      $display("FAIL drain_timeout cycles=%0d exp>=22",
               cyc_ir.size());
    end else begin
      bad = 0;
      for (int c = 8; c <= 20; c++) if (cyc_ir[c]) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL drain_ir_high cycles=%0d exp=0", bad);
      end
      checks++;
      if (cyc_ihs[21] !== 1'b1) begin
        failures++;
        $display("FAIL drain_first_fill got=%b exp=1",
                 cyc_ihs[21]);
      end
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_data(0, i)) begin
        failures++;
        $display("FAIL drain_beat%0d got=%0d exp=%0d",
                 i, q_data[i], exp_data(0, i));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(2 * W, 8 * W, 1'b1, 50);
    checks++;
    if (timed_out || accepted != 2 * W) begin
      failures++;
      $display("FAIL bp_count beats=%0d blocks=%0d exp=%0d/%0d",
               q_data.size(), accepted, 8 * W, 2 * W);
    end
    checks++;
    if (stall_err != 0) begin
      failures++;
      $display("FAIL bp_stable got=%0d exp=0", stall_err);
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_data(50, i)
          || q_last[i] !== exp_last(i)) begin
        failures++;
        $display("FAIL bp_beat%0d got=%0d/%b exp=%0d/%b",
                 i, q_data[i], q_last[i],
                 exp_data(50, i), exp_last(i));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(W, 4, 1'b0, 0);
    #5;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd8) begin
      failures++;
      $display("FAIL pre_reset got=%b/%0d exp=1/8",
               out_valid, out_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL async_reset got=%b/%0d exp=0/0",
               out_valid, out_data);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(W, 4 * W, 1'b0, 100);
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL rst_timeout beats=%0d exp=%0d",
               q_data.size(), 4 * W);
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_data(100, i)
          || q_last[i] !== exp_last(i)) begin
        failures++;
        $display("FAIL rst_beat%0d got=%0d/%b exp=%0d/%b",
                 i, q_data[i], q_last[i],
                 exp_data(100, i), exp_last(i));
      end
    end
  endtask

`ifdef RASTER_EOF_EN
  task automatic test_eof();
    do_reset();
    drive(2 * H * W, 8 * H * W, 1'b0, 0);
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL eof_timeout beats=%0d exp=%0d",
               q_data.size(), 8 * H * W);
    end
    for (int i = 0; i < q_eof.size(); i++) begin
      bit e;
      e = (i % (4 * H * W)) == (4 * H * W - 1);
      checks++;
      if (q_eof[i] !== e) begin
        failures++;
        $display("FAIL eof_beat%0d got=%b exp=%b",
                 i, q_eof[i], e);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_drain();
    test_backpressure();
    test_async_reset();
`ifdef RASTER_EOF_EN
    test_eof();
`endif
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
